// File: rtl/ten_gig_pkg.sv
// Types and helpers shared by the 10G receive-path blocks.
package ten_gig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2,
        WAIT    = 2'd3
    } wr_state_e;

    // Width of a circular-buffer pointer: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gate_sdp_ram.sv
// Simple dual-port beat RAM: one write port, one synchronous read port.
module gate_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; rdata holds while re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/crc_frame_gate.sv
// Store-and-forward gate: buffers MAC rx frames until their CRC verdict, then
// releases good frames on a backpressurable AXIS master and erases the rest.
module crc_frame_gate
    import ten_gig_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int USER_W = 80,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] s_axis_rdata,
    input  logic [USER_W-1:0] s_axis_ruser,
    input  logic [KEEP_W-1:0] s_axis_rkeep,
    input  logic              s_axis_rlast,
    input  logic              s_axis_rvalid,
    input  logic              i_crc_error,
    input  logic              i_crc_valid,
    output logic [DATA_W-1:0] m_axis_rdata,
    output logic [USER_W-1:0] m_axis_ruser,
    output logic [KEEP_W-1:0] m_axis_rkeep,
    output logic              m_axis_rlast,
    output logic              m_axis_rvalid,
    input  logic              m_axis_rready,
    output logic [CNT_W-1:0]  o_good_cnt,
    output logic [CNT_W-1:0]  o_crc_drop_cnt,
    output logic [CNT_W-1:0]  o_ovf_drop_cnt
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam int ENT_W = 1 + KEEP_W + USER_W + DATA_W;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    wr_state_e        state_r;
    logic [PTR_W-1:0] wr_ptr_r, frm_ptr_r, cmt_ptr_r, rd_ptr_r;
    logic             ovf_r, skip_r, ign_r;
    logic [CNT_W-1:0] good_cnt_r, crc_cnt_r, ovf_cnt_r;

    logic             full_s, intr_s, intr_end_s, own_beat_s, cap_s, wr_ok_s;
    logic             fr_ovf_s, v_wait_s, v_free_s, v_ign_s, v_now_s, resolve_s;
    logic             res_ovf_s, res_crc_s, res_good_s, ign_nxt_s;
    logic [PTR_W-1:0] frm_base_s, wr_ptr_nxt_s;

    logic             pend_r, out_vld_r, skid_vld_r;
    logic [ENT_W-1:0] out_ent_r, skid_ent_r, ram_rdata_s;
    logic             avail_s, pop_s, issue_s;
    logic [1:0]       occ_s;

    // Decode input beats and verdicts against the write-side state.
    // A beat seen in WAIT (or while swallowing such a beat's frame) belongs to
    // an intruding frame whose own later verdict must be skipped via ign_r.
    always_comb begin
        full_s     = (wr_ptr_r - rd_ptr_r) == DEPTH_P;
        intr_s     = s_axis_rvalid && (skip_r || (state_r == WAIT));
        intr_end_s = intr_s && s_axis_rlast;
        own_beat_s = s_axis_rvalid && !intr_s;
        cap_s      = own_beat_s && ((state_r == IDLE) || (state_r == RECV));
        wr_ok_s    = cap_s && !full_s;
        fr_ovf_s   = ovf_r || (cap_s && full_s);
        v_wait_s   = i_crc_valid && (state_r == WAIT);
        v_free_s   = i_crc_valid && !v_wait_s && !ign_r;
        v_ign_s    = i_crc_valid && !v_wait_s && ign_r;
        v_now_s    = v_free_s && own_beat_s && s_axis_rlast;
        resolve_s  = v_wait_s || v_now_s;
        res_ovf_s  = resolve_s && fr_ovf_s;
        res_crc_s  = resolve_s && !fr_ovf_s && i_crc_error;
        res_good_s = resolve_s && !fr_ovf_s && !i_crc_error;
        ign_nxt_s  = (ign_r && !v_ign_s) || (intr_end_s && !v_free_s);
        frm_base_s = (state_r == IDLE) ? wr_ptr_r : frm_ptr_r;
        if (res_ovf_s || res_crc_s) begin
            wr_ptr_nxt_s = frm_base_s;
        end else if (wr_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
    end

    // Write-side FSM: pointers, per-frame flags and verdict bookkeeping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r   <= IDLE;
            wr_ptr_r  <= {PTR_W{1'b0}};
            frm_ptr_r <= {PTR_W{1'b0}};
            cmt_ptr_r <= {PTR_W{1'b0}};
            ovf_r     <= 1'b0;
            skip_r    <= 1'b0;
            ign_r     <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            ign_r    <= ign_nxt_s;
            if (intr_s) begin
                skip_r <= !s_axis_rlast;
            end
            if (res_good_s) begin
                cmt_ptr_r <= wr_ptr_nxt_s;
            end
            if (cap_s && (state_r == IDLE)) begin
                frm_ptr_r <= wr_ptr_r;
            end
            if (resolve_s) begin
                ovf_r <= 1'b0;
            end else if (cap_s && full_s) begin
                ovf_r <= 1'b1;
            end
            case (state_r)
                IDLE, RECV: begin
                    if (cap_s) begin
                        if (s_axis_rlast) begin
                            state_r <= v_now_s ? IDLE : WAIT;
                        end else if (full_s) begin
                            state_r <= DISCARD;
                        end else begin
                            state_r <= RECV;
                        end
                    end
                end
                DISCARD: begin
                    if (own_beat_s && s_axis_rlast) begin
                        state_r <= v_now_s ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (v_wait_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Saturating frame statistics
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            good_cnt_r <= {CNT_W{1'b0}};
            crc_cnt_r  <= {CNT_W{1'b0}};
            ovf_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            good_cnt_r <= sat_add(good_cnt_r, {1'b0, res_good_s});
            crc_cnt_r  <= sat_add(crc_cnt_r, {1'b0, res_crc_s});
            ovf_cnt_r  <= sat_add(ovf_cnt_r, {1'b0, res_ovf_s} + {1'b0, intr_end_s});
        end
    end

    gate_sdp_ram #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_ok_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata ({s_axis_rlast, s_axis_rkeep, s_axis_ruser, s_axis_rdata}),
        .re    (issue_s),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Read credit: in-flight RAM read plus output and skid slots never exceed two
    always_comb begin
        avail_s = rd_ptr_r != cmt_ptr_r;
        pop_s   = out_vld_r && m_axis_rready;
        occ_s   = {1'b0, out_vld_r} + {1'b0, skid_vld_r} + {1'b0, pend_r};
        issue_s = avail_s && ((occ_s - {1'b0, pop_s}) < 2'd2);
    end

    // Read pipeline: RAM fetch, output register and skid slot
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            pend_r     <= 1'b0;
            out_vld_r  <= 1'b0;
            out_ent_r  <= {ENT_W{1'b0}};
            skid_vld_r <= 1'b0;
            skid_ent_r <= {ENT_W{1'b0}};
        end else begin
            pend_r <= issue_s;
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (!out_vld_r || pop_s) begin
                if (skid_vld_r) begin
                    out_ent_r  <= skid_ent_r;
                    out_vld_r  <= 1'b1;
                    skid_vld_r <= pend_r;
                    if (pend_r) begin
                        skid_ent_r <= ram_rdata_s;
                    end
                end else if (pend_r) begin
                    out_ent_r <= ram_rdata_s;
                    out_vld_r <= 1'b1;
                end else begin
                    out_vld_r <= 1'b0;
                end
            end else if (pend_r) begin
                skid_ent_r <= ram_rdata_s;
                skid_vld_r <= 1'b1;
            end
        end
    end

    assign {m_axis_rlast, m_axis_rkeep, m_axis_ruser, m_axis_rdata} = out_ent_r;
    assign m_axis_rvalid  = out_vld_r;
    assign o_good_cnt     = good_cnt_r;
    assign o_crc_drop_cnt = crc_cnt_r;
    assign o_ovf_drop_cnt = ovf_cnt_r;

endmodule

// File: tb/tb_crc_frame_gate.sv
// Directed bench for crc_frame_gate: a DEPTH=256 instance for the main tests
// and a DEPTH=16 instance for the overflow test, sharing the input stimulus.
module tb_crc_frame_gate;

    typedef logic [152:0] beat_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [63:0] s_data;
    logic [79:0] s_user;
    logic [7:0]  s_keep;
    logic        s_last, s_valid, crc_err, crc_valid, rready, tog_en;

    logic [63:0] m_data, m16_data;
    logic [79:0] m_user, m16_user;
    logic [7:0]  m_keep, m16_keep;
    logic        m_last, m_valid, m16_last, m16_valid;
    logic [31:0] good, crcd, ovfd, good16, crcd16, ovfd16;
    beat_t       m_beat, m16_beat;

    beat_t exp_q[$], got_q[$], got16_q[$];
    int    checks = 0, errors = 0, hold_err = 0;
    logic  hold_pend = 1'b0;
    beat_t hold_beat;

    assign m_beat   = {m_last, m_keep, m_user, m_data};
    assign m16_beat = {m16_last, m16_keep, m16_user, m16_data};

    always #5 clk = ~clk;

    crc_frame_gate dut (
        .i_clk(clk), .i_rst(i_rst),
        .s_axis_rdata(s_data), .s_axis_ruser(s_user), .s_axis_rkeep(s_keep),
        .s_axis_rlast(s_last), .s_axis_rvalid(s_valid),
        .i_crc_error(crc_err), .i_crc_valid(crc_valid),
        .m_axis_rdata(m_data), .m_axis_ruser(m_user), .m_axis_rkeep(m_keep),
        .m_axis_rlast(m_last), .m_axis_rvalid(m_valid), .m_axis_rready(rready),
        .o_good_cnt(good), .o_crc_drop_cnt(crcd), .o_ovf_drop_cnt(ovfd)
    );

    crc_frame_gate #(.DEPTH(16)) dut16 (
        .i_clk(clk), .i_rst(i_rst),
        .s_axis_rdata(s_data), .s_axis_ruser(s_user), .s_axis_rkeep(s_keep),
        .s_axis_rlast(s_last), .s_axis_rvalid(s_valid),
        .i_crc_error(crc_err), .i_crc_valid(crc_valid),
        .m_axis_rdata(m16_data), .m_axis_ruser(m16_user), .m_axis_rkeep(m16_keep),
        .m_axis_rlast(m16_last), .m_axis_rvalid(m16_valid), .m_axis_rready(rready),
        .o_good_cnt(good16), .o_crc_drop_cnt(crcd16), .o_ovf_drop_cnt(ovfd16)
    );

    // Collect accepted beats and watch that a stalled beat stays put
    always @(negedge clk) begin
        if (!i_rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend && !(m_valid && (m_beat == hold_beat))) hold_err <= hold_err + 1;
            hold_pend <= m_valid && !rready;
            hold_beat <= m_beat;
            if (m_valid && rready) got_q.push_back(m_beat);
            if (m16_valid && rready) got16_q.push_back(m16_beat);
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) rready = ~rready;
    endtask

    function automatic beat_t mk_beat(input int id, input int i, input bit last, input logic [7:0] keep);
        logic [63:0] d;
        logic [79:0] u;
        d = {16'hDA7A, id[7:0], i[7:0], 32'hC0DE_0000 ^ 32'(id * 256 + i)};
        u = {16'h5EED, i[7:0], id[7:0], 48'h0123_4567_89AB};
        return {last, keep, u, d};
    endfunction

    task automatic drive(input beat_t b);
        s_last = b[152]; s_keep = b[151:144]; s_user = b[143:64]; s_data = b[63:0];
        s_valid = 1'b1;
    endtask

    task automatic send_frame(input int id, input int n, input logic [7:0] lk,
                              input bit coin, input bit err);
        for (int i = 0; i < n; i++) begin
            drive(mk_beat(id, i, i == n - 1, (i == n - 1) ? lk : 8'hFF));
            if ((i == n - 1) && coin) begin
                crc_valid = 1'b1;
                crc_err   = err;
            end
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; crc_valid = 1'b0; crc_err = 1'b0;
    endtask

    task automatic expect_frame(input int id, input int n, input logic [7:0] lk);
        for (int i = 0; i < n; i++) exp_q.push_back(mk_beat(id, i, i == n - 1, (i == n - 1) ? lk : 8'hFF));
    endtask

    task automatic verdict(input bit err);
        crc_valid = 1'b1;
        crc_err   = err;
        tick();
        crc_valid = 1'b0;
        crc_err   = 1'b0;
    endtask

    task automatic drain(input bit sel);
        for (int c = 0; c < 400; c++) begin
            if ((sel ? got16_q.size() : got_q.size()) >= exp_q.size()) break;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic cmp_q(input string tag, input bit sel);
        beat_t g[$];
        if (sel) g = got16_q; else g = got_q;
        check({tag, "_count"}, 160'(g.size()), 160'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < g.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), 160'(g[k]), 160'(exp_q[k]));
    endtask

    task automatic cnt3(input string tag, input bit sel, input int g, input int c, input int o);
        check({tag, "_good"}, 160'(sel ? good16 : good), 160'(g));
        check({tag, "_crc"},  160'(sel ? crcd16 : crcd), 160'(c));
        check({tag, "_ovf"},  160'(sel ? ovfd16 : ovfd), 160'(o));
    endtask

    task automatic reset_dut();
        i_rst = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; crc_valid = 1'b0; crc_err = 1'b0;
        tog_en = 1'b0; rready = 1'b0;
        tick(); tick();
        i_rst = 1'b1;
        got_q.delete(); got16_q.delete(); exp_q.delete();
        tick();
    endtask

    initial begin
        i_rst = 1'b1; s_data = 64'd0; s_user = 80'd0; s_keep = 8'd0;
        s_last = 1'b0; s_valid = 1'b0; crc_err = 1'b0; crc_valid = 1'b0;
        rready = 1'b0; tog_en = 1'b0;
        #2 i_rst = 1'b0;
        tick();
        check("rst_valid", 160'(m_valid), 160'(1'b0));
        check("rst_beat", 160'(m_beat), 160'(0));
        cnt3("rst", 1'b0, 0, 0, 0);
        reset_dut();

        // 1: good 5-beat frame, verdict two cycles after last
        rready = 1'b1;
        send_frame(1, 5, 8'h0F, 1'b0, 1'b0);
        expect_frame(1, 5, 8'h0F);
        tick();
        verdict(1'b0);
        tick(); tick();
        check("t1_lat_valid", 160'(m_valid), 160'(1'b1));
        check("t1_lat_beat", 160'(m_beat), 160'(exp_q[0]));
        drain(1'b0);
        cmp_q("t1", 1'b0);
        cnt3("t1", 1'b0, 1, 0, 0);

        // 2: bad frame erased, next good frame reuses its space
        reset_dut();
        rready = 1'b1;
        send_frame(2, 5, 8'h0F, 1'b0, 1'b0);
        tick();
        verdict(1'b1);
        send_frame(3, 3, 8'hF0, 1'b0, 1'b0);
        expect_frame(3, 3, 8'hF0);
        check("t2_frm_ptr", 160'(dut.frm_ptr_r), 160'(0));
        tick();
        verdict(1'b0);
        drain(1'b0);
        cmp_q("t2", 1'b0);
        cnt3("t2", 1'b0, 1, 1, 0);

        // 3: 8 back-to-back frames, verdict with last, rready toggling
        reset_dut();
        rready = 1'b1;
        tog_en = 1'b1;
        for (int f = 0; f < 8; f++) begin
            send_frame(10 + f, 8, 8'hFF >> f, 1'b1, 1'b0);
            expect_frame(10 + f, 8, 8'hFF >> f);
        end
        drain(1'b0);
        tog_en = 1'b0;
        cmp_q("t3", 1'b0);
        cnt3("t3", 1'b0, 8, 0, 0);
        check("t3_hold", 160'(hold_err), 160'(0));

        // 4: DEPTH=16 overflow drop, then a small frame passes
        reset_dut();
        rready = 1'b0;
        send_frame(30, 20, 8'h0F, 1'b0, 1'b0);
        tick();
        verdict(1'b0);
        repeat (3) tick();
        check("t4_no_valid", 160'(m16_valid), 160'(1'b0));
        cnt3("t4a", 1'b1, 0, 0, 1);
        rready = 1'b1;
        got16_q.delete();
        send_frame(31, 4, 8'h3C, 1'b1, 1'b0);
        expect_frame(31, 4, 8'h3C);
        drain(1'b1);
        cmp_q("t4", 1'b1);
        cnt3("t4b", 1'b1, 1, 0, 1);

        // 5: frame starting during WAIT is discarded, pending verdict honoured
        reset_dut();
        rready = 1'b1;
        send_frame(40, 4, 8'h1F, 1'b0, 1'b0);
        send_frame(41, 3, 8'hFF, 1'b0, 1'b0);
        expect_frame(40, 4, 8'h1F);
        tick();
        verdict(1'b0);
        tick();
        verdict(1'b0);
        drain(1'b0);
        cmp_q("t5", 1'b0);
        cnt3("t5a", 1'b0, 1, 0, 1);
        send_frame(42, 2, 8'h03, 1'b1, 1'b0);
        expect_frame(42, 2, 8'h03);
        drain(1'b0);
        cmp_q("t5b", 1'b0);
        cnt3("t5b", 1'b0, 2, 0, 1);

        // 6: reset mid-frame and mid-readout
        reset_dut();
        rready = 1'b0;
        send_frame(50, 5, 8'h0F, 1'b1, 1'b0);
        repeat (3) tick();
        check("t6_pre_valid", 160'(m_valid), 160'(1'b1));
        drive(mk_beat(51, 0, 1'b0, 8'hFF));
        tick();
        drive(mk_beat(51, 1, 1'b0, 8'hFF));
        tick();
        i_rst = 1'b0;
        #1;
        check("t6_rst_valid", 160'(m_valid), 160'(1'b0));
        check("t6_rst_beat", 160'(m_beat), 160'(0));
        cnt3("t6_rst", 1'b0, 0, 0, 0);
        s_valid = 1'b0;
        tick(); tick();
        i_rst = 1'b1;
        got_q.delete(); exp_q.delete();
        tick();
        rready = 1'b1;
        send_frame(52, 5, 8'h0F, 1'b0, 1'b0);
        expect_frame(52, 5, 8'h0F);
        tick();
        verdict(1'b0);
        drain(1'b0);
        cmp_q("t6", 1'b0);
        cnt3("t6", 1'b0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
